execute_muldiv: RTL and testbench

Parametrised successor of the pipeline execute stage. Keeps operand forwarding, ALU source selection, link-register handling and the E/M pipeline register, and adds an iterative multiply/divide unit with architectural HI/LO registers. Adds a stall handshake toward the hazard unit and a flush input. Sits between decode and memory stages; WIDTH and the multiply latency are generic.

---
 rtl/execute_muldiv.sv | 214 +++++++++++++++++++++
 tb/tb_execute_muldiv.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/execute_muldiv.sv
// Execute stage with operand forwarding, ALU, link handling, E/M register and an
// iterative multiply/divide unit that owns the architectural HI/LO registers.
module execute_muldiv #(
    parameter int WIDTH       = 32,
    parameter int REG_W       = 5,
    parameter int MUL_LATENCY = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_e_i,
    input  logic             reg_write_e_i,
    input  logic             mem_write_e_i,
    input  logic             mem_to_reg_e_i,
    input  logic             reg_dst_e_i,
    input  logic             link_e_i,
    input  logic [1:0]       alu_src_e_i,
    input  logic [3:0]       alu_control_e_i,
    input  logic [3:0]       md_op_e_i,
    input  logic [WIDTH-1:0] pc_plus_4_e_i,
    input  logic [WIDTH-1:0] reg_data_1_e_i,
    input  logic [WIDTH-1:0] reg_data_2_e_i,
    input  logic [WIDTH-1:0] sign_imm_e_i,
    input  logic [WIDTH-1:0] result_w_i,
    input  logic [REG_W-1:0] rt_e_i,
    input  logic [REG_W-1:0] rd_e_i,
    input  logic [4:0]       shamt_e_i,
    input  logic [1:0]       forward_a_e_i,
    input  logic [1:0]       forward_b_e_i,
    output logic             stall_o,
    output logic             md_busy_o,
    output logic [REG_W-1:0] write_reg_e_o,
    output logic             reg_write_m_o,
    output logic             mem_write_m_o,
    output logic             mem_to_reg_m_o,
    output logic [WIDTH-1:0] alu_out_m_o,
    output logic [WIDTH-1:0] write_data_m_o,
    output logic [REG_W-1:0] write_reg_m_o
);
    localparam int SH_W    = $clog2(WIDTH);
    localparam int CNT_MAX = (WIDTH + 1 > MUL_LATENCY) ? WIDTH + 1 : MUL_LATENCY;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [3:0] OP_MULT  = 4'd1, OP_MULTU = 4'd2, OP_DIV  = 4'd3, OP_DIVU = 4'd4;
    localparam logic [3:0] OP_MFHI  = 4'd5, OP_MFLO  = 4'd6, OP_MTHI = 4'd7, OP_MTLO = 4'd8;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_t;

    state_t             state;
    logic [CNT_W-1:0]   count;
    logic [WIDTH-1:0]   hi, lo;
    logic [WIDTH-1:0]   op_a, op_b, dvs, rem, quo;
    logic               op_signed, neg_q, neg_r;

    logic [WIDTH-1:0]   fwd_a, fwd_b, src_a, src_b, alu_result, e_result;
    logic [SH_W-1:0]    sh;
    logic               md_valid, busy;
    logic               div_signed, a_neg, b_neg;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [2*WIDTH-1:0] mul_a_ext, mul_b_ext, product;
    logic [WIDTH:0]     rem_shift, rem_diff;

    always_comb begin
        case (forward_a_e_i)
            2'b01:   fwd_a = result_w_i;
            2'b10:   fwd_a = alu_out_m_o;
            default: fwd_a = reg_data_1_e_i;
        endcase
        case (forward_b_e_i)
            2'b01:   fwd_b = result_w_i;
            2'b10:   fwd_b = alu_out_m_o;
            default: fwd_b = reg_data_2_e_i;
        endcase
    end

    assign src_a = alu_src_e_i[1] ? {{(WIDTH-5){1'b0}}, shamt_e_i} : fwd_a;
    assign src_b = alu_src_e_i[0] ? sign_imm_e_i : fwd_b;
    assign sh    = src_a[SH_W-1:0];

    // Encoding of the existing ALU; shifts move B by A, LUI moves B to the upper half.
    always_comb begin
        alu_result = '0;
        case (alu_control_e_i)
            4'd0:  alu_result = src_a & src_b;
            4'd1:  alu_result = src_a | src_b;
            4'd2:  alu_result = src_a + src_b;
            4'd3:  alu_result = src_a ^ src_b;
            4'd4:  alu_result = ~(src_a | src_b);
            4'd5:  alu_result = {{(WIDTH-1){1'b0}}, (src_a < src_b)};
            4'd6:  alu_result = src_a - src_b;
            4'd7:  alu_result = {{(WIDTH-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
            4'd8:  alu_result = src_b << sh;
            4'd9:  alu_result = src_b >> sh;
            4'd10: alu_result = $signed(src_b) >>> sh;
            4'd11: alu_result = src_b << (WIDTH / 2);
            default: alu_result = '0;
        endcase
    end

    assign e_result      = (md_op_e_i == OP_MFHI) ? hi :
                           (md_op_e_i == OP_MFLO) ? lo : alu_result;
    assign write_reg_e_o = link_e_i ? {REG_W{1'b1}} : (reg_dst_e_i ? rd_e_i : rt_e_i);

    assign md_valid  = (md_op_e_i >= OP_MULT) && (md_op_e_i <= OP_MTLO);
    assign busy      = (state != S_IDLE);
    assign md_busy_o = busy;
    assign stall_o   = busy & md_valid;

    assign div_signed = (md_op_e_i == OP_DIV);
    assign a_neg      = div_signed & fwd_a[WIDTH-1];
    assign b_neg      = div_signed & fwd_b[WIDTH-1];
    assign a_mag      = a_neg ? -fwd_a : fwd_a;
    assign b_mag      = b_neg ? -fwd_b : fwd_b;

    assign mul_a_ext = op_signed ? {{WIDTH{op_a[WIDTH-1]}}, op_a} : {{WIDTH{1'b0}}, op_a};
    assign mul_b_ext = op_signed ? {{WIDTH{op_b[WIDTH-1]}}, op_b} : {{WIDTH{1'b0}}, op_b};
    assign product   = mul_a_ext * mul_b_ext;

    // One restoring step: a clear top bit of the difference means the trial subtract fits.
    assign rem_shift = {rem, quo[WIDTH-1]};
    assign rem_diff  = rem_shift - {1'b0, dvs};

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state     <= S_IDLE;
            count     <= '0;
            hi        <= '0;
            lo        <= '0;
            op_a      <= '0;
            op_b      <= '0;
            dvs       <= '0;
            rem       <= '0;
            quo       <= '0;
            op_signed <= 1'b0;
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (!flush_e_i) begin
                        case (md_op_e_i)
                            OP_MULT, OP_MULTU: begin
                                op_a      <= fwd_a;
                                op_b      <= fwd_b;
                                op_signed <= (md_op_e_i == OP_MULT);
                                count     <= CNT_W'(MUL_LATENCY);
                                state     <= S_MUL;
                            end
                            OP_DIV, OP_DIVU: begin
                                op_a  <= fwd_a;
                                op_b  <= fwd_b;
                                quo   <= a_mag;
                                dvs   <= b_mag;
                                rem   <= '0;
                                neg_q <= a_neg ^ b_neg;
                                neg_r <= a_neg;
                                count <= CNT_W'(WIDTH + 1);
                                state <= S_DIV;
                            end
                            OP_MTHI: hi <= fwd_a;
                            OP_MTLO: lo <= fwd_a;
                            default: ;
                        endcase
                    end
                end
                S_MUL: begin
                    count <= count - CNT_W'(1);
                    if (count == CNT_W'(1)) begin
                        {hi, lo} <= product;
                        state    <= S_IDLE;
                    end
                end
                S_DIV: begin
                    count <= count - CNT_W'(1);
                    if (count == CNT_W'(1)) begin
                        if (op_b == '0) begin
                            lo <= '1;
                            hi <= op_a;
                        end else begin
                            lo <= neg_q ? -quo : quo;
                            hi <= neg_r ? -rem : rem;
                        end
                        state <= S_IDLE;
                    end else if (!rem_diff[WIDTH]) begin
                        rem <= rem_diff[WIDTH-1:0];
                        quo <= {quo[WIDTH-2:0], 1'b1};
                    end else begin
                        rem <= rem_shift[WIDTH-1:0];
                        quo <= {quo[WIDTH-2:0], 1'b0};
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // A stalled or flushed instruction leaves a bubble in M.
    always_ff @(posedge clk_i) begin
        if (!rst_i || stall_o || flush_e_i) begin
            reg_write_m_o  <= 1'b0;
            mem_write_m_o  <= 1'b0;
            mem_to_reg_m_o <= 1'b0;
            alu_out_m_o    <= '0;
            write_data_m_o <= '0;
            write_reg_m_o  <= '0;
        end else begin
            reg_write_m_o  <= reg_write_e_i;
            mem_write_m_o  <= mem_write_e_i;
            mem_to_reg_m_o <= mem_to_reg_e_i;
            alu_out_m_o    <= e_result;
            write_data_m_o <= link_e_i ? pc_plus_4_e_i : fwd_b;
            write_reg_m_o  <= write_reg_e_o;
        end
    end
endmodule

// File: tb/tb_execute_muldiv.sv
// Scoreboard bench: the driver runs an arithmetic model and queues expectations,
// monitors compare the DUT outputs against the queue at the falling edge.
module tb_execute_muldiv;
    localparam int ML = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_i = 1'b0, flush_e_i = 1'b0;
    logic        reg_write_e_i = 1'b0, mem_write_e_i = 1'b0, mem_to_reg_e_i = 1'b0;
    logic        reg_dst_e_i = 1'b0, link_e_i = 1'b0;
    logic [1:0]  alu_src_e_i = '0, forward_a_e_i = '0, forward_b_e_i = '0;
    logic [3:0]  alu_control_e_i = '0, md_op_e_i = '0;
    logic [31:0] pc_plus_4_e_i = '0, reg_data_1_e_i = '0, reg_data_2_e_i = '0;
    logic [31:0] sign_imm_e_i = '0, result_w_i = '0;
    logic [4:0]  rt_e_i = '0, rd_e_i = '0, shamt_e_i = '0;
    logic        stall_o, md_busy_o, reg_write_m_o, mem_write_m_o, mem_to_reg_m_o;
    logic [4:0]  write_reg_e_o, write_reg_m_o;
    logic [31:0] alu_out_m_o, write_data_m_o;

    execute_muldiv #(.WIDTH(32), .REG_W(5), .MUL_LATENCY(ML)) dut (
        .clk_i(clk), .rst_i(rst_i), .flush_e_i(flush_e_i),
        .reg_write_e_i(reg_write_e_i), .mem_write_e_i(mem_write_e_i),
        .mem_to_reg_e_i(mem_to_reg_e_i), .reg_dst_e_i(reg_dst_e_i), .link_e_i(link_e_i),
        .alu_src_e_i(alu_src_e_i), .alu_control_e_i(alu_control_e_i), .md_op_e_i(md_op_e_i),
        .pc_plus_4_e_i(pc_plus_4_e_i), .reg_data_1_e_i(reg_data_1_e_i),
        .reg_data_2_e_i(reg_data_2_e_i), .sign_imm_e_i(sign_imm_e_i), .result_w_i(result_w_i),
        .rt_e_i(rt_e_i), .rd_e_i(rd_e_i), .shamt_e_i(shamt_e_i),
        .forward_a_e_i(forward_a_e_i), .forward_b_e_i(forward_b_e_i),
        .stall_o(stall_o), .md_busy_o(md_busy_o), .write_reg_e_o(write_reg_e_o),
        .reg_write_m_o(reg_write_m_o), .mem_write_m_o(mem_write_m_o),
        .mem_to_reg_m_o(mem_to_reg_m_o), .alu_out_m_o(alu_out_m_o),
        .write_data_m_o(write_data_m_o), .write_reg_m_o(write_reg_m_o)
    );

    // Narrow instance exercised with a short directed sequence.
    logic        h_rst = 1'b0;
    logic [3:0]  h_md_op = '0;
    logic [15:0] h_a = '0, h_b = '0;
    logic        h_stall, h_busy, h_rw, h_mw, h_m2r;
    logic [4:0]  h_wreg_e, h_wreg_m;
    logic [15:0] h_alu, h_wd;

    execute_muldiv #(.WIDTH(16), .REG_W(5), .MUL_LATENCY(ML)) dut16 (
        .clk_i(clk), .rst_i(h_rst), .flush_e_i(1'b0),
        .reg_write_e_i(1'b1), .mem_write_e_i(1'b0), .mem_to_reg_e_i(1'b0),
        .reg_dst_e_i(1'b0), .link_e_i(1'b0), .alu_src_e_i(2'b00),
        .alu_control_e_i(4'd2), .md_op_e_i(h_md_op),
        .pc_plus_4_e_i(16'h0), .reg_data_1_e_i(h_a), .reg_data_2_e_i(h_b),
        .sign_imm_e_i(16'h0), .result_w_i(16'h0), .rt_e_i(5'd0), .rd_e_i(5'd0),
        .shamt_e_i(5'd0), .forward_a_e_i(2'b00), .forward_b_e_i(2'b00),
        .stall_o(h_stall), .md_busy_o(h_busy), .write_reg_e_o(h_wreg_e),
        .reg_write_m_o(h_rw), .mem_write_m_o(h_mw), .mem_to_reg_m_o(h_m2r),
        .alu_out_m_o(h_alu), .write_data_m_o(h_wd), .write_reg_m_o(h_wreg_m)
    );

    typedef struct packed {
        logic rst, flush, reg_write, mem_write, mem_to_reg, reg_dst, link;
        logic [1:0]  alu_src;
        logic [3:0]  alu_ctl, md_op;
        logic [31:0] pc4, rd1, rd2, imm, res_w;
        logic [4:0]  rt, rd, shamt;
        logic [1:0]  fa, fb;
    } instr_t;

    typedef struct packed {
        logic        stall, busy;
        logic [4:0]  wreg_e;
        logic        rw, mw, m2r;
        logic [31:0] alu, wd;
        logic [4:0]  wreg_m;
    } exp_t;

    typedef struct packed { logic stall; logic [15:0] alu; } exp16_t;

    exp_t   q[$];
    exp16_t q16[$];
    int     total = 0;
    int     bad = 0;
    int     cyc = 0;

    // Reference state: M register contents, HI/LO and the pending multiply/divide.
    logic        m_rw = 0, m_mw = 0, m_m2r = 0;
    logic [31:0] m_alu = 0, m_wd = 0;
    logic [4:0]  m_wreg = 0;
    logic [31:0] hi_m = 0, lo_m = 0, pend_hi = 0, pend_lo = 0;
    int          busy_left = 0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, got, want);
        end
    endtask

    function automatic logic [31:0] alu_ref(input logic [3:0] c, input logic [31:0] a,
                                            input logic [31:0] b);
        case (c)
            4'd0:  return a & b;
            4'd1:  return a | b;
            4'd2:  return a + b;
            4'd3:  return a ^ b;
            4'd4:  return ~(a | b);
            4'd5:  return (a < b) ? 32'd1 : 32'd0;
            4'd6:  return a - b;
            4'd7:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd8:  return b << a[4:0];
            4'd9:  return b >> a[4:0];
            4'd10: return $signed(b) >>> a[4:0];
            4'd11: return {b[15:0], 16'h0};
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] fwd(input logic [1:0] s, input logic [31:0] r,
                                        input logic [31:0] w, input logic [31:0] m);
        return (s == 2'b01) ? w : (s == 2'b10) ? m : r;
    endfunction

    task automatic cycle(input instr_t i, output logic stalled);
        exp_t        e;
        logic [31:0] fa, fb, a, b, res;
        logic [63:0] p;
        longint      sa, sb, sq, sr;
        logic        mdv;
        rst_i = i.rst; flush_e_i = i.flush; reg_write_e_i = i.reg_write;
        mem_write_e_i = i.mem_write; mem_to_reg_e_i = i.mem_to_reg; reg_dst_e_i = i.reg_dst;
        link_e_i = i.link; alu_src_e_i = i.alu_src; alu_control_e_i = i.alu_ctl;
        md_op_e_i = i.md_op; pc_plus_4_e_i = i.pc4; reg_data_1_e_i = i.rd1;
        reg_data_2_e_i = i.rd2; sign_imm_e_i = i.imm; result_w_i = i.res_w;
        rt_e_i = i.rt; rd_e_i = i.rd; shamt_e_i = i.shamt;
        forward_a_e_i = i.fa; forward_b_e_i = i.fb;

        fa  = fwd(i.fa, i.rd1, i.res_w, m_alu);
        fb  = fwd(i.fb, i.rd2, i.res_w, m_alu);
        mdv = (i.md_op >= 4'd1) && (i.md_op <= 4'd8);
        stalled  = (busy_left > 0) && mdv;
        e.stall  = stalled;
        e.busy   = (busy_left > 0);
        e.wreg_e = i.link ? 5'd31 : (i.reg_dst ? i.rd : i.rt);
        a   = i.alu_src[1] ? {27'd0, i.shamt} : fa;
        b   = i.alu_src[0] ? i.imm : fb;
        res = (i.md_op == 4'd5) ? hi_m : (i.md_op == 4'd6) ? lo_m : alu_ref(i.alu_ctl, a, b);

        if (!i.rst || stalled || i.flush) begin
            m_rw = 0; m_mw = 0; m_m2r = 0; m_alu = 0; m_wd = 0; m_wreg = 0;
        end else begin
            m_rw = i.reg_write; m_mw = i.mem_write; m_m2r = i.mem_to_reg;
            m_alu = res; m_wd = i.link ? i.pc4 : fb; m_wreg = e.wreg_e;
        end

        if (!i.rst) begin
            busy_left = 0; hi_m = 0; lo_m = 0;
        end else if (busy_left > 0) begin
            busy_left--;
            if (busy_left == 0) begin hi_m = pend_hi; lo_m = pend_lo; end
        end else if (!i.flush) begin
            case (i.md_op)
                4'd1: begin
                    sa = $signed(fa); sb = $signed(fb); p = sa * sb;
                    {pend_hi, pend_lo} = p; busy_left = ML;
                end
                4'd2: begin
                    p = {32'd0, fa} * {32'd0, fb};
                    {pend_hi, pend_lo} = p; busy_left = ML;
                end
                4'd3, 4'd4: begin
                    if (fb == 0) begin
                        pend_lo = 32'hFFFF_FFFF; pend_hi = fa;
                    end else if (i.md_op == 4'd3) begin
                        sa = $signed(fa); sb = $signed(fb); sq = sa / sb; sr = sa % sb;
                        pend_lo = sq[31:0]; pend_hi = sr[31:0];
                    end else begin
                        pend_lo = fa / fb; pend_hi = fa % fb;
                    end
                    busy_left = 33;
                end
                4'd7: hi_m = fa;
                4'd8: lo_m = fa;
                default: ;
            endcase
        end

        e.rw = m_rw; e.mw = m_mw; e.m2r = m_m2r; e.alu = m_alu; e.wd = m_wd; e.wreg_m = m_wreg;
        q.push_back(e);
        @(posedge clk); #1;
    endtask

    task automatic run(input instr_t i);
        logic s;
        cycle(i, s);
    endtask

    // Repeats an instruction while it is stalled, as the hazard unit would hold it.
    task automatic issue(input instr_t i);
        logic s;
        for (int k = 0; k < 64; k++) begin
            cycle(i, s);
            if (!s) break;
        end
    endtask

    function automatic instr_t nop();
        instr_t i = '0;
        i.rst = 1'b1;
        return i;
    endfunction

    function automatic instr_t md(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        instr_t i = nop();
        i.md_op = op; i.rd1 = a; i.rd2 = b;
        return i;
    endfunction

    function automatic logic [31:0] rval();
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return 32'd1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'($urandom_range(0, 20));
            default: return $urandom();
        endcase
    endfunction

    function automatic instr_t rnd();
        instr_t i = nop();
        i.rst = ($urandom_range(0, 99) != 0);
        i.flush = ($urandom_range(0, 7) == 0);
        i.reg_write = 1'($urandom_range(0, 1)); i.mem_write = 1'($urandom_range(0, 1));
        i.mem_to_reg = 1'($urandom_range(0, 1)); i.reg_dst = 1'($urandom_range(0, 1));
        i.link = ($urandom_range(0, 7) == 0);
        i.alu_src = 2'($urandom_range(0, 3)); i.alu_ctl = 4'($urandom_range(0, 15));
        i.md_op = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'd0;
        i.pc4 = $urandom(); i.rd1 = rval(); i.rd2 = rval(); i.imm = rval(); i.res_w = rval();
        i.rt = 5'($urandom_range(0, 31)); i.rd = 5'($urandom_range(0, 31));
        i.shamt = 5'($urandom_range(0, 31));
        i.fa = 2'($urandom_range(0, 3)); i.fb = 2'($urandom_range(0, 3));
        return i;
    endfunction

    exp_t prev;
    bit   have_prev = 0;
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (have_prev) begin
                chk("reg_write_m", 32'(reg_write_m_o), 32'(prev.rw));
                chk("mem_write_m", 32'(mem_write_m_o), 32'(prev.mw));
                chk("mem_to_reg_m", 32'(mem_to_reg_m_o), 32'(prev.m2r));
                chk("alu_out_m", alu_out_m_o, prev.alu);
                chk("write_data_m", write_data_m_o, prev.wd);
                chk("write_reg_m", 32'(write_reg_m_o), 32'(prev.wreg_m));
                $display("cyc %0d: alu_m=%h wd_m=%h wreg_m=%0d stall=%b busy=%b",
                         cyc, alu_out_m_o, write_data_m_o, write_reg_m_o, stall_o, md_busy_o);
            end
            have_prev = 0;
            if (q.size() > 0) begin
                prev = q.pop_front();
                chk("stall", 32'(stall_o), 32'(prev.stall));
                chk("md_busy", 32'(md_busy_o), 32'(prev.busy));
                chk("write_reg_e", 32'(write_reg_e_o), 32'(prev.wreg_e));
                have_prev = 1;
            end
        end
    end

    exp16_t prev16;
    bit     have_prev16 = 0;
    initial begin
        forever begin
            @(negedge clk);
            if (have_prev16) begin
                chk("w16_alu_out_m", 32'(h_alu), 32'(prev16.alu));
                $display("w16: alu_m=%h stall=%b", h_alu, h_stall);
            end
            have_prev16 = 0;
            if (q16.size() > 0) begin
                prev16 = q16.pop_front();
                chk("w16_stall", 32'(h_stall), 32'(prev16.stall));
                have_prev16 = 1;
            end
        end
    end

    task automatic c16(input logic r, input logic [3:0] op, input logic [15:0] a,
                       input logic [15:0] b, input logic st, input logic [15:0] alu);
        exp16_t e;
        h_rst = r; h_md_op = op; h_a = a; h_b = b;
        e.stall = st; e.alu = alu;
        q16.push_back(e);
        @(posedge clk); #1;
    endtask

    initial begin
        instr_t i;
        @(posedge clk); #1;
        i = nop(); i.rst = 1'b0;
        run(i); run(i);

        // Reset aborts an in-flight multiply and clears preloaded HI/LO.
        issue(md(4'd7, 32'hAAAA_0000, 0));
        issue(md(4'd8, 32'h0000_5555, 0));
        issue(md(4'd6, 0, 0));
        issue(md(4'd1, 32'd3, 32'd5));
        run(nop()); run(nop());
        i = md(4'd5, 0, 0); i.rst = 1'b0; run(i);
        issue(md(4'd5, 0, 0));
        issue(md(4'd6, 0, 0));

        issue(md(4'd1, 32'hFFFF_FFFF, 32'd2));
        issue(md(4'd5, 0, 0));
        issue(md(4'd6, 0, 0));
        issue(md(4'd2, 32'hFFFF_FFFF, 32'd2));
        issue(md(4'd5, 0, 0));
        issue(md(4'd6, 0, 0));

        issue(md(4'd3, 32'hFFFF_FFF9, 32'd2));
        issue(md(4'd6, 0, 0));
        issue(md(4'd5, 0, 0));
        issue(md(4'd4, 32'd7, 32'd0));
        issue(md(4'd6, 0, 0));
        issue(md(4'd5, 0, 0));
        issue(md(4'd3, 32'h8000_0000, 32'hFFFF_FFFF));
        issue(md(4'd7, 32'h0BAD_0000, 0));
        issue(md(4'd5, 0, 0));
        issue(md(4'd6, 0, 0));

        i = nop(); i.alu_ctl = 4'd2; i.reg_write = 1; i.rd1 = 2; i.rd2 = 3; i.rd = 9; i.reg_dst = 1;
        run(i);
        i = nop(); i.alu_ctl = 4'd2; i.reg_write = 1; i.fa = 2'b10; i.rd1 = 100; i.rd2 = 3;
        run(i);
        i = nop(); i.alu_ctl = 4'd2; i.fb = 2'b01; i.res_w = 9; i.rd2 = 44; i.mem_write = 1;
        run(i);
        i = nop(); i.link = 1; i.reg_write = 1; i.pc4 = 32'h0040_0004; i.rt = 4;
        run(i);

        i = md(4'd3, 32'd100, 32'd7); i.flush = 1'b1; run(i);
        issue(md(4'd6, 0, 0));
        issue(md(4'd8, 32'h0000_1234, 0));
        issue(md(4'd6, 0, 0));

        for (int k = 0; k < 500; k++) run(rnd());

        c16(1'b0, 4'd0, 16'h0, 16'h0, 1'b0, 16'h0000);
        c16(1'b1, 4'd2, 16'hFFFF, 16'hFFFF, 1'b0, 16'hFFFE);
        for (int k = 0; k < ML; k++) c16(1'b1, 4'd5, 16'h0, 16'h0, 1'b1, 16'h0000);
        c16(1'b1, 4'd5, 16'h0, 16'h0, 1'b0, 16'hFFFE);
        c16(1'b1, 4'd6, 16'h0, 16'h0, 1'b0, 16'h0001);
        c16(1'b1, 4'd0, 16'h0, 16'h0, 1'b0, 16'h0000);

        repeat (3) @(posedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
